oam_dma_ctrl: RTL and testbench

Sprite-DMA sequencer and CPU bus arbiter for the NES core. It detects a CPU write to the OAM-DMA register and stalls the cpu6502 core via `cpu_rdy`. It then takes the CPU memory bus and copies one 256-byte page of CPU address space into PPU OAM, one read/write pair per CPU cycle pair, before returning the bus to the CPU. It sits between `cpu6502_top`'s external address/data bus, the CPU memory, and the PPU OAM write port.

---
 rtl/oam_dma_ctrl_if.sv | 28 ++
 rtl/oam_dma_ctrl.sv | 98 +++++++++
 tb/tb_oam_dma_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side bus, DMA memory port and OAM write port of the sprite-DMA sequencer.
// master = the DMA controller, slave = the surrounding CPU/memory/PPU fabric.
interface oam_dma_ctrl_if;
   logic        cpu_ce;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_we;
   logic [7:0]  oam_base;
   logic [7:0]  mem_rdata;
   logic        cpu_rdy;
   logic        bus_sel;
   logic [15:0] dma_addr;
   logic        dma_rd;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_wdata;
   logic        oam_we;
   logic        busy;

   modport master (
      input  cpu_ce, cpu_addr, cpu_wdata, cpu_we, oam_base, mem_rdata,
      output cpu_rdy, bus_sel, dma_addr, dma_rd, oam_addr, oam_wdata, oam_we, busy
   );

   modport slave (
      output cpu_ce, cpu_addr, cpu_wdata, cpu_we, oam_base, mem_rdata,
      input  cpu_rdy, bus_sel, dma_addr, dma_rd, oam_addr, oam_wdata, oam_we, busy
   );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA sequencer: halts the CPU on a $4014 write, copies one 256-byte
// page into OAM as READ/WRITE cycle pairs, then returns the bus to the CPU.
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR = 16'h4014
) (
   input logic            CLK,
   input logic            RESET_n,
   oam_dma_ctrl_if.master bus
);
   typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

   state_t     r_state;
   state_t     w_next;
   logic       r_odd;
   logic [7:0] r_page;
   logic [7:0] r_idx;
   logic [7:0] r_oam_ptr;
   logic [7:0] r_data;
   logic       w_trigger;
   logic       w_cpu_rdy;
   logic       w_bus_sel;
   logic       w_dma_rd;
   logic       w_oam_we;
   logic       w_busy;

   assign w_trigger = bus.cpu_ce && bus.cpu_we && (bus.cpu_addr == DMA_REG_ADDR);

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_cpu_rdy = 1'b0;
      w_bus_sel = 1'b0;
      w_dma_rd  = 1'b0;
      w_oam_we  = 1'b0;
      w_busy    = 1'b1;
      case (r_state)
         IDLE: begin
            w_cpu_rdy = 1'b1;
            w_busy    = 1'b0;
            if (w_trigger) w_next = HALT;
         end
         // ALIGN pads an odd-parity HALT so reads always start on an even cycle
         HALT:  if (bus.cpu_ce) w_next = r_odd ? ALIGN : READ;
         ALIGN: if (bus.cpu_ce) w_next = READ;
         READ: begin
            w_bus_sel = 1'b1;
            w_dma_rd  = 1'b1;
            if (bus.cpu_ce) w_next = WRITE;
         end
         WRITE: begin
            w_bus_sel = 1'b1;
            w_oam_we  = 1'b1;
            if (bus.cpu_ce) w_next = (r_idx == 8'hFF) ? IDLE : READ;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         r_odd     <= 1'b0;
         r_page    <= '0;
         r_idx     <= '0;
         r_oam_ptr <= '0;
         r_data    <= '0;
      end else if (bus.cpu_ce) begin
         r_odd <= ~r_odd;
         case (r_state)
            IDLE: begin
               if (w_trigger) begin
                  r_page    <= bus.cpu_wdata;
                  r_oam_ptr <= bus.oam_base;
                  r_idx     <= '0;
               end
            end
            READ: r_data <= bus.mem_rdata;
            WRITE: begin
               r_oam_ptr <= r_oam_ptr + 8'd1;
               if (r_idx != 8'hFF) r_idx <= r_idx + 8'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.cpu_rdy   = w_cpu_rdy;
   assign bus.busy      = w_busy;
   assign bus.bus_sel   = w_bus_sel;
   assign bus.dma_rd    = w_dma_rd;
   assign bus.oam_we    = w_oam_we;
   assign bus.dma_addr  = {r_page, r_idx};
   assign bus.oam_addr  = r_oam_ptr;
   assign bus.oam_wdata = r_data;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: one cpu_ce pulse every 4 CLKs, a behavioural
// CPU memory and an OAM image rebuilt from the observed oam_we cycles.
module tb_oam_dma_ctrl;
   logic CLK = 1'b0;
   logic RESET_n = 1'b0;
   always #5 CLK = ~CLK;

   oam_dma_ctrl_if bus();

   oam_dma_ctrl #(.DMA_REG_ADDR(16'h4014)) dut (
      .CLK    (CLK),
      .RESET_n(RESET_n),
      .bus    (bus)
   );

   int unsigned n_pass = 0;
   int unsigned n_chk  = 0;
   int unsigned n_ce, stall, we_cnt, rd_cnt, dma_err, pre_cnt;
   logic [15:0] exp_dma;
   logic [7:0]  first_oam, last_oam;
   logic [7:0]  oam [256];

   function automatic logic [7:0] mem_val(input logic [15:0] a);
      return a[7:0] ^ 8'hA5 ^ a[15:8] ^ 8'h02;
   endfunction

   always_comb bus.mem_rdata = mem_val(bus.dma_addr);

   // One CPU cycle: inputs already set by the caller, outputs observed before the ce edge.
   task automatic cyc();
      @(negedge CLK);
      bus.cpu_ce = 1'b1;
      if (!bus.cpu_rdy) stall++;
      if (!bus.cpu_rdy && !bus.bus_sel && bus.busy) pre_cnt++;
      if (bus.dma_rd) begin
         if (bus.dma_addr !== exp_dma) dma_err++;
         exp_dma = exp_dma + 16'd1;
         rd_cnt++;
      end
      if (bus.oam_we) begin
         if (we_cnt == 0) first_oam = bus.oam_addr;
         last_oam = bus.oam_addr;
         oam[bus.oam_addr] = bus.oam_wdata;
         we_cnt++;
      end
      @(negedge CLK);
      bus.cpu_ce = 1'b0;
      n_ce++;
      @(negedge CLK);
      @(negedge CLK);
   endtask

   task automatic clr_mon(input logic [15:0] start);
      stall = 0; we_cnt = 0; rd_cnt = 0; dma_err = 0; pre_cnt = 0;
      exp_dma = start; first_oam = 8'hXX; last_oam = 8'hXX;
   endtask

   task automatic fill_oam(input logic [7:0] v);
      for (int i = 0; i < 256; i++) oam[i] = v;
   endtask

   // Starts a DMA whose HALT cycle has the requested parity; optionally runs it to completion.
   task automatic start_dma(input logic [7:0] page, input logic [7:0] base,
                            input bit halt_odd, input bit run_out);
      int unsigned guard;
      bus.oam_base = base;
      bus.cpu_we   = 1'b0;
      while (((n_ce % 2) == 0) != halt_odd) cyc();
      clr_mon({page, 8'h00});
      bus.cpu_addr = 16'h4014; bus.cpu_wdata = page; bus.cpu_we = 1'b1;
      cyc();
      bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'h00;
      guard = 0;
      while (run_out && bus.busy && guard < 700) begin cyc(); guard++; end
   endtask

   function automatic int unsigned page_errs(input logic [7:0] page, input logic [7:0] base);
      int unsigned e = 0;
      for (int i = 0; i < 256; i++)
         if (oam[8'(base + 8'(i))] !== mem_val({page, 8'(i)})) e++;
      return e;
   endfunction

   task automatic test_reset();
      bus.cpu_ce = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.oam_base = '0;
      RESET_n = 1'b0;
      repeat (3) @(negedge CLK);
      n_chk++; if (bus.cpu_rdy !== 1'b1) $display("FAIL reset_cpu_rdy got %b want 1", bus.cpu_rdy); else n_pass++;
      n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
      n_chk++; if (bus.bus_sel !== 1'b0) $display("FAIL reset_bus_sel got %b want 0", bus.bus_sel); else n_pass++;
      n_chk++; if (bus.dma_rd !== 1'b0) $display("FAIL reset_dma_rd got %b want 0", bus.dma_rd); else n_pass++;
      n_chk++; if (bus.oam_we !== 1'b0) $display("FAIL reset_oam_we got %b want 0", bus.oam_we); else n_pass++;
      n_chk++; if (bus.dma_addr !== 16'h0000) $display("FAIL reset_dma_addr got %h want 0000", bus.dma_addr); else n_pass++;
      n_chk++; if (bus.oam_addr !== 8'h00) $display("FAIL reset_oam_addr got %h want 00", bus.oam_addr); else n_pass++;
      n_chk++; if (bus.oam_wdata !== 8'h00) $display("FAIL reset_oam_wdata got %h want 00", bus.oam_wdata); else n_pass++;
      RESET_n = 1'b1;
      n_ce = 0;
   endtask

   task automatic test_idle_traffic();
      int unsigned busy_seen = 0;
      clr_mon(16'h0000);
      for (int i = 0; i < 1000; i++) begin
         bus.cpu_addr  = 16'($urandom);
         if (bus.cpu_addr == 16'h4014) bus.cpu_addr = 16'h4013;
         bus.cpu_wdata = 8'($urandom);
         bus.cpu_we    = 1'($urandom);
         cyc();
         if (bus.busy !== 1'b0 || bus.cpu_rdy !== 1'b1) busy_seen++;
      end
      bus.cpu_we = 1'b0;
      n_chk++; if (busy_seen !== 0) $display("FAIL idle_busy got %0d busy cycles want 0", busy_seen); else n_pass++;
      n_chk++; if (we_cnt !== 0) $display("FAIL idle_oam_we got %0d writes want 0", we_cnt); else n_pass++;
   endtask

   task automatic test_no_dma();
      bus.cpu_addr = 16'h4015; bus.cpu_wdata = 8'h02; bus.cpu_we = 1'b1;
      cyc();
      n_chk++; if (bus.busy !== 1'b0) $display("FAIL w4015_busy got %b want 0", bus.busy); else n_pass++;
      bus.cpu_addr = 16'h4014; bus.cpu_we = 1'b0;
      cyc();
      n_chk++; if (bus.busy !== 1'b0) $display("FAIL r4014_busy got %b want 0", bus.busy); else n_pass++;
      cyc();
      n_chk++; if (bus.cpu_rdy !== 1'b1) $display("FAIL r4014_cpu_rdy got %b want 1", bus.cpu_rdy); else n_pass++;
      bus.cpu_addr = 16'h0000;
   endtask

   task automatic test_even();
      fill_oam(8'h00);
      start_dma(8'h02, 8'h00, 1'b0, 1'b1);
      n_chk++; if (bus.busy !== 1'b0) $display("FAIL even_done got busy %b want 0", bus.busy); else n_pass++;
      n_chk++; if (stall !== 513) $display("FAIL even_stall got %0d want 513", stall); else n_pass++;
      n_chk++; if (pre_cnt !== 1) $display("FAIL even_pre_cycles got %0d want 1", pre_cnt); else n_pass++;
      n_chk++; if (rd_cnt !== 256) $display("FAIL even_reads got %0d want 256", rd_cnt); else n_pass++;
      n_chk++; if (dma_err !== 0) $display("FAIL even_dma_addr got %0d bad addresses want 0", dma_err); else n_pass++;
      n_chk++; if (we_cnt !== 256) $display("FAIL even_oam_we got %0d want 256", we_cnt); else n_pass++;
      n_chk++; if (page_errs(8'h02, 8'h00) !== 0) $display("FAIL even_oam_data got %0d bad bytes want 0", page_errs(8'h02, 8'h00)); else n_pass++;
      n_chk++; if (bus.cpu_rdy !== 1'b1 || bus.bus_sel !== 1'b0) $display("FAIL even_release got rdy=%b sel=%b want rdy=1 sel=0", bus.cpu_rdy, bus.bus_sel); else n_pass++;
   endtask

   task automatic test_odd_align();
      fill_oam(8'h00);
      start_dma(8'h02, 8'h00, 1'b1, 1'b1);
      n_chk++; if (stall !== 514) $display("FAIL odd_stall got %0d want 514", stall); else n_pass++;
      n_chk++; if (pre_cnt !== 2) $display("FAIL odd_pre_cycles got %0d want 2", pre_cnt); else n_pass++;
      n_chk++; if (page_errs(8'h02, 8'h00) !== 0) $display("FAIL odd_oam_data got %0d bad bytes want 0", page_errs(8'h02, 8'h00)); else n_pass++;
   endtask

   task automatic test_wrap();
      fill_oam(8'h00);
      start_dma(8'h03, 8'hFC, 1'b0, 1'b1);
      n_chk++; if (first_oam !== 8'hFC) $display("FAIL wrap_first got %h want FC", first_oam); else n_pass++;
      n_chk++; if (last_oam !== 8'hFB) $display("FAIL wrap_last got %h want FB", last_oam); else n_pass++;
      n_chk++; if (dma_err !== 0) $display("FAIL wrap_dma_addr got %0d bad addresses want 0", dma_err); else n_pass++;
      n_chk++; if (page_errs(8'h03, 8'hFC) !== 0) $display("FAIL wrap_oam_data got %0d bad bytes want 0", page_errs(8'h03, 8'hFC)); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int unsigned guard = 0;
      int unsigned e_lo = 0;
      int unsigned e_hi = 0;
      fill_oam(8'h5A);
      start_dma(8'h05, 8'h00, 1'b0, 1'b0);
      while (we_cnt < 100 && guard < 400) begin cyc(); guard++; end
      RESET_n = 1'b0;
      #1;
      n_chk++; if (bus.cpu_rdy !== 1'b1) $display("FAIL midrst_cpu_rdy got %b want 1", bus.cpu_rdy); else n_pass++;
      n_chk++; if (bus.bus_sel !== 1'b0) $display("FAIL midrst_bus_sel got %b want 0", bus.bus_sel); else n_pass++;
      repeat (2) @(negedge CLK);
      RESET_n = 1'b1;
      n_ce = 0;
      repeat (20) cyc();
      for (int i = 0; i < 100; i++) if (oam[i] !== mem_val({8'h05, 8'(i)})) e_lo++;
      for (int i = 100; i < 256; i++) if (oam[i] !== 8'h5A) e_hi++;
      n_chk++; if (we_cnt !== 100) $display("FAIL midrst_writes got %0d want 100", we_cnt); else n_pass++;
      n_chk++; if (e_lo !== 0) $display("FAIL midrst_written got %0d bad bytes want 0", e_lo); else n_pass++;
      n_chk++; if (e_hi !== 0) $display("FAIL midrst_untouched got %0d changed bytes want 0", e_hi); else n_pass++;
   endtask

   task automatic test_back_to_back();
      fill_oam(8'h00);
      start_dma(8'h02, 8'h00, 1'b0, 1'b1);
      n_chk++; if (stall !== 513) $display("FAIL fresh_stall got %0d want 513", stall); else n_pass++;
      n_chk++; if (we_cnt !== 256) $display("FAIL fresh_oam_we got %0d want 256", we_cnt); else n_pass++;
      n_chk++; if (page_errs(8'h02, 8'h00) !== 0) $display("FAIL fresh_oam_data got %0d bad bytes want 0", page_errs(8'h02, 8'h00)); else n_pass++;
   endtask

   initial begin
      n_ce = 0;
      clr_mon(16'h0000);
      test_reset();
      test_idle_traffic();
      test_no_dma();
      test_even();
      test_odd_align();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
